// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised modulo up/down counter used as a timebase and event counter.
// A programmable prescaler produces a tick every (prescale+1) enabled cycles.
// On each tick the count steps up or down within 0..MAX_VALUE. When it steps
// past the terminal value it either wraps (free-run) or stops and flags done
// (one-shot). Synchronous clear and parallel load override stepping.
//
// Parameters
//   WIDTH       count register width (1..32)
//   MAX_VALUE   terminal value, 1 <= MAX_VALUE <= 2**WIDTH-1
//   PRESCALE_W  width of the prescale divider input
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high, highest priority
//   enable       in   advances the prescaler; low holds all state
//   up_down      in   1 = count up, 0 = count down
//   oneshot      in   1 = stop at terminal, 0 = wrap
//   prescale     in   step every prescale+1 enabled cycles
//   clear        in   synchronous clear to 0
//   load         in   parallel load strobe (honoured regardless of enable)
//   load_value   in   value loaded on load, clamped to MAX_VALUE
//   count        out  current count, registered
//   wrap         out  one-cycle pulse on wrap-around, registered
//   done         out  one-shot has stopped at terminal, registered
//   at_terminal  out  combinational terminal decode for the current direction
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MAX_VALUE  = 32'((64'd1 << WIDTH) - 64'd1),
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  oneshot,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   output logic [WIDTH-1:0]      count,
   output logic                  wrap,
   output logic                  done,
   output logic                  at_terminal
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]            state;
   logic [0:0]            state_next;
   logic [PRESCALE_W-1:0] presc;
   logic [PRESCALE_W-1:0] presc_next;
   logic [WIDTH-1:0]      count_next;
   logic                  wrap_next;
   logic                  done_next;
   logic                  running;
   logic                  tick;

   assign running = enable && (state == ST_RUN);

   // >= rather than == so that lowering prescale below the current
   // prescaler value forces a tick on the next cycle instead of a long
   // roll-over through the full prescaler range.
   assign tick = running && (presc >= prescale);

   always_comb begin
      state_next = state;
      presc_next = presc;
      count_next = count;
      wrap_next  = 1'b0;
      done_next  = done;

      if (clear) begin
         count_next = '0;
         presc_next = '0;
         done_next  = 1'b0;
         state_next = ST_RUN;
      end else if (load) begin
         count_next = (load_value > MAX_C) ? MAX_C : load_value;
         presc_next = '0;
         done_next  = 1'b0;
         state_next = ST_RUN;
      end else if (running) begin
         presc_next = tick ? '0 : presc + PRESCALE_W'(1);
         if (tick) begin
            if (up_down) begin
               if (count < MAX_C) begin
                  count_next = count + WIDTH'(1);
               end else if (oneshot) begin
                  done_next  = 1'b1;
                  state_next = ST_HOLD;
               end else begin
                  count_next = '0;
                  wrap_next  = 1'b1;
               end
            end else begin
               if (count != '0) begin
                  count_next = count - WIDTH'(1);
               end else if (oneshot) begin
                  done_next  = 1'b1;
                  state_next = ST_HOLD;
               end else begin
                  count_next = MAX_C;
                  wrap_next  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_RUN;
         presc <= '0;
         count <= '0;
         wrap  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         presc <= presc_next;
         count <= count_next;
         wrap  <= wrap_next;
         done  <= done_next;
      end
   end

   assign at_terminal = up_down ? (count == MAX_C) : (count == '0);

endmodule
